// File: rtl/esp8266_pkg.sv
// Shared definitions for the ESP8266 link: ASCII literals, frame geometry and
// the per-position byte-class table of the m("TT.T","HH","SS")\r\n frame.
package esp8266_pkg;

    localparam logic [7:0] CH_M     = 8'h6D;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_QUOT  = 8'h22;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    localparam int unsigned FRAME_LEN  = 21;
    localparam int unsigned NUM_DIGITS = 7;

    typedef enum logic [2:0] {
        CLS_LIT  = 3'd0,
        DIG_TE_T = 3'd1,
        DIG_TE_U = 3'd2,
        DIG_TE_F = 3'd3,
        DIG_HU_T = 3'd4,
        DIG_HU_U = 3'd5,
        DIG_SM_T = 3'd6,
        DIG_SM_U = 3'd7
    } byte_class_e;

    function automatic byte_class_e pos_class(input logic [4:0] pos);
        case (pos)
            5'd3:    return DIG_TE_T;
            5'd4:    return DIG_TE_U;
            5'd6:    return DIG_TE_F;
            5'd10:   return DIG_HU_T;
            5'd11:   return DIG_HU_U;
            5'd15:   return DIG_SM_T;
            5'd16:   return DIG_SM_U;
            default: return CLS_LIT;
        endcase
    endfunction

    function automatic logic [7:0] pos_lit(input logic [4:0] pos);
        case (pos)
            5'd0:    return CH_M;
            5'd1:    return CH_LPAR;
            5'd2:    return CH_QUOT;
            5'd5:    return CH_DOT;
            5'd7:    return CH_QUOT;
            5'd8:    return CH_COMMA;
            5'd9:    return CH_QUOT;
            5'd12:   return CH_QUOT;
            5'd13:   return CH_COMMA;
            5'd14:   return CH_QUOT;
            5'd17:   return CH_QUOT;
            5'd18:   return CH_RPAR;
            5'd19:   return CH_CR;
            5'd20:   return CH_LF;
            default: return 8'h00;
        endcase
    endfunction

    // Shadow slot 0..6 follows the order te_t, te_u, te_f, hu_t, hu_u, sm_t, sm_u.
    function automatic logic [2:0] digit_slot(input byte_class_e cls);
        logic [2:0] raw;
        raw = cls;
        return raw - 3'd1;
    endfunction

endpackage

// File: rtl/esp8266_ascii2bin.sv
// Combinational ASCII digit check and nibble extraction for one byte.
module esp8266_ascii2bin
    import esp8266_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       is_digit,
    output logic [3:0] nibble
);

    logic [7:0] diff;

    assign diff     = ascii - CH_ZERO;
    assign is_digit = (ascii >= CH_ZERO) && (ascii <= CH_NINE);
    assign nibble   = diff[3:0];

endmodule

// File: rtl/esp8266_decode.sv
// Receive-side frame parser for the ESP8266 link: validates m("TT.T","HH","SS")\r\n
// byte by byte and publishes the ASCII fields and their binary values on commit.
module esp8266_decode #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd2_500_000,
    parameter int unsigned FRAME_LEN      = esp8266_pkg::FRAME_LEN
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_valid,
    input  logic [7:0]  Rx_data,
    output logic [23:0] oTeData,
    output logic [15:0] oHuData,
    output logic [15:0] oSmData,
    output logic [9:0]  oTeBin,
    output logic [6:0]  oHuBin,
    output logic [6:0]  oSmBin,
    output logic        Frame_valid,
    output logic        Frame_err,
    output logic [7:0]  Err_cnt,
    output logic        Busy
);
    import esp8266_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [4:0]                  pos, pos_next;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic [NUM_DIGITS-1:0][7:0]  shadow, shadow_next;
    logic                        set_valid, set_err;
    logic                        rx_is_digit;
    logic [3:0]                  rx_nib_unused;
    logic [NUM_DIGITS-1:0]       sh_dig_unused;
    logic [NUM_DIGITS-1:0][3:0]  nib;
    byte_class_e                 cls;
    logic [7:0]                  lit;
    logic                        byte_ok;
    logic [9:0]                  te_bin_c;
    logic [6:0]                  hu_bin_c, sm_bin_c;

    esp8266_ascii2bin u_rx_a2b (
        .ascii    (Rx_data),
        .is_digit (rx_is_digit),
        .nibble   (rx_nib_unused)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_sh
        esp8266_ascii2bin u_a2b (
            .ascii    (shadow[g]),
            .is_digit (sh_dig_unused[g]),
            .nibble   (nib[g])
        );
    end

    assign cls     = pos_class(pos);
    assign lit     = pos_lit(pos);
    assign byte_ok = (cls == CLS_LIT) ? (Rx_data == lit) : rx_is_digit;
    assign Busy    = (pos != 5'd0);

    assign te_bin_c = 10'(nib[0]) * 10'd100 + 10'(nib[1]) * 10'd10 + 10'(nib[2]);
    assign hu_bin_c = 7'(nib[3]) * 7'd10 + 7'(nib[4]);
    assign sm_bin_c = 7'(nib[5]) * 7'd10 + 7'(nib[6]);

    // Next position, timeout counter, shadow writes and pulse requests.
    always_comb begin
        pos_next    = pos;
        cnt_next    = cnt;
        shadow_next = shadow;
        set_valid   = 1'b0;
        set_err     = 1'b0;
        if (Rx_valid) begin
            cnt_next = '0;
            if (pos == 5'd0) begin
                if (Rx_data == CH_M) begin
                    pos_next = 5'd1;
                end else begin
                    pos_next = 5'd0;
                end
            end else if (byte_ok) begin
                if (cls != CLS_LIT) begin
                    shadow_next[digit_slot(cls)] = Rx_data;
                end else begin
                    shadow_next = shadow;
                end
                if (pos == 5'(FRAME_LEN - 1)) begin
                    set_valid = 1'b1;
                    pos_next  = 5'd0;
                end else begin
                    pos_next = pos + 5'd1;
                end
            end else begin
                // A stray 'm' is taken as the start of a fresh frame.
                set_err     = 1'b1;
                shadow_next = '0;
                pos_next    = (Rx_data == CH_M) ? 5'd1 : 5'd0;
            end
        end else if (pos == 5'd0) begin
            cnt_next = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            set_err     = 1'b1;
            shadow_next = '0;
            pos_next    = 5'd0;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Parser state, pulses, error counter and committed outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pos         <= 5'd0;
            cnt         <= '0;
            shadow      <= '0;
            Frame_valid <= 1'b0;
            Frame_err   <= 1'b0;
            Err_cnt     <= 8'd0;
            oTeData     <= 24'd0;
            oHuData     <= 16'd0;
            oSmData     <= 16'd0;
            oTeBin      <= 10'd0;
            oHuBin      <= 7'd0;
            oSmBin      <= 7'd0;
        end else begin
            pos         <= pos_next;
            cnt         <= cnt_next;
            shadow      <= shadow_next;
            Frame_valid <= set_valid;
            Frame_err   <= set_err;
            if (set_err && (Err_cnt != 8'hFF)) begin
                Err_cnt <= Err_cnt + 8'd1;
            end else begin
                Err_cnt <= Err_cnt;
            end
            // The closing '\n' is not a digit, so the shadows are already complete here.
            if (set_valid) begin
                oTeData <= {shadow[0], shadow[1], shadow[2]};
                oHuData <= {shadow[3], shadow[4]};
                oSmData <= {shadow[5], shadow[6]};
                oTeBin  <= te_bin_c;
                oHuBin  <= hu_bin_c;
                oSmBin  <= sm_bin_c;
            end else begin
                oTeData <= oTeData;
                oHuData <= oHuData;
                oSmData <= oSmData;
                oTeBin  <= oTeBin;
                oHuBin  <= oHuBin;
                oSmBin  <= oSmBin;
            end
        end
    end

endmodule
